load_store_unit: RTL

Data-memory side of the rv32 core: consumes the decoder's `Load`/`Store`/`fun3` controls, the ALU-computed address and rs2 data, and runs a req/ack transaction on the data-memory bus. It generates byte enables and lane-replicated write data, and sign/zero-extends load data. It stalls the core until the access completes, and flags misaligned, illegal-width or timed-out accesses.

---
 rtl/rv32_pkg.sv | 26 ++
 rtl/lsu_align.sv | 71 +++++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/rv32_pkg.sv
// Shared rv32 definitions: load/store width encodings, LSU state and bus command payload.
package rv32_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = XLEN / 8;

  localparam logic [2:0] LS_B  = 3'b000;
  localparam logic [2:0] LS_H  = 3'b001;
  localparam logic [2:0] LS_W  = 3'b010;
  localparam logic [2:0] LS_BU = 3'b100;
  localparam logic [2:0] LS_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } lsu_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [BE_W-1:0] be;
    logic [XLEN-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store data replication, access legality and load extension.
module lsu_align
  import rv32_pkg::*;
(
  input  logic            store,
  input  logic [2:0]      fun3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [BE_W-1:0] be_c,
  output logic [XLEN-1:0] wdata_c,
  output logic            misaligned_c,
  output logic            illegal_c,
  output logic [XLEN-1:0] rdata_c
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  assign byte_lane = rdata[{addr_lo, 3'b000} +: 8];
  assign half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Store byte enables and lane-replicated write data.
  always_comb begin
    be_c    = '0;
    wdata_c = '0;
    case (fun3)
      LS_B: begin
        be_c    = 4'b0001 << addr_lo;
        wdata_c = {4{wdata[7:0]}};
      end
      LS_H: begin
        be_c    = 4'b0011 << addr_lo;
        wdata_c = {2{wdata[15:0]}};
      end
      LS_W: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
      default: ;
    endcase
  end

  // Unsigned widths exist only for loads; everything outside the table is illegal.
  always_comb begin
    illegal_c = 1'b1;
    case (fun3)
      LS_B, LS_H, LS_W: illegal_c = 1'b0;
      LS_BU, LS_HU:     illegal_c = store;
      default:          illegal_c = 1'b1;
    endcase
  end

  // Halfwords need bit 0 clear, words need both low bits clear.
  assign misaligned_c = ((fun3[1:0] == 2'b01) && addr_lo[0]) ||
                        ((fun3[1:0] == 2'b10) && (addr_lo != 2'b00));

  // Load lane selection with sign or zero extension.
  always_comb begin
    rdata_c = '0;
    case (fun3)
      LS_B:  rdata_c = {{(XLEN-8){byte_lane[7]}}, byte_lane};
      LS_BU: rdata_c = {{(XLEN-8){1'b0}}, byte_lane};
      LS_H:  rdata_c = {{(XLEN-16){half_lane[15]}}, half_lane};
      LS_HU: rdata_c = {{(XLEN-16){1'b0}}, half_lane};
      LS_W:  rdata_c = rdata;
      default: rdata_c = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory load/store unit: req/ack bus sequencing, stall generation and error/timeout reporting.
module load_store_unit
  import rv32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_i,
  input  logic            store_i,
  input  logic [2:0]      fun3_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic            done_o,
  output logic            err_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [BE_W-1:0] mem_be_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_cmd_t        cmd_q, cmd_d;
  logic            req_q, req_d;
  logic [2:0]      fun3_q, fun3_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [XLEN-1:0] rdata_q, rdata_d;

  logic            access;
  logic            in_idle;
  logic            sel_store;
  logic [2:0]      sel_fun3;
  logic [1:0]      sel_addr_lo;
  logic [BE_W-1:0] be_c;
  logic [XLEN-1:0] wdata_c;
  logic            misaligned_c;
  logic            illegal_c;
  logic [XLEN-1:0] rdata_c;

  assign access  = load_i | store_i;
  assign in_idle = (state_q == IDLE);

  // Lane logic sees the live instruction in IDLE and the latched access afterwards.
  assign sel_store   = in_idle ? store_i      : cmd_q.we;
  assign sel_fun3    = in_idle ? fun3_i       : fun3_q;
  assign sel_addr_lo = in_idle ? addr_i[1:0]  : addr_lo_q;

  lsu_align u_align (
    .store        (sel_store),
    .fun3         (sel_fun3),
    .addr_lo      (sel_addr_lo),
    .wdata        (wdata_i),
    .rdata        (mem_rdata_i),
    .be_c         (be_c),
    .wdata_c      (wdata_c),
    .misaligned_c (misaligned_c),
    .illegal_c    (illegal_c),
    .rdata_c      (rdata_c)
  );

  // Next-state and next-output logic for the access sequencer.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    req_d     = req_q;
    fun3_d    = fun3_q;
    addr_lo_d = addr_lo_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = '0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (misaligned_c || illegal_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            req_d       = 1'b1;
            fun3_d      = fun3_i;
            addr_lo_d   = addr_i[1:0];
            cmd_d.we    = store_i;
            cmd_d.addr  = {addr_i[XLEN-1:2], 2'b00};
            cmd_d.be    = store_i ? be_c : '0;
            cmd_d.wdata = store_i ? wdata_c : '0;
          end
        end
      end
      REQ: begin
        if (mem_ack_i) begin
          state_d  = DONE;
          done_d   = 1'b1;
          req_d    = 1'b0;
          rdata_d  = cmd_q.we ? '0 : rdata_c;
          cmd_d.we = 1'b0;
          cmd_d.be = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d  = DONE;
          done_d   = 1'b1;
          err_d    = 1'b1;
          req_d    = 1'b0;
          cmd_d.we = 1'b0;
          cmd_d.be = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cmd_q     <= '0;
      req_q     <= 1'b0;
      fun3_q    <= '0;
      addr_lo_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      req_q     <= req_d;
      fun3_q    <= fun3_d;
      addr_lo_q <= addr_lo_d;
      done_q    <= done_d;
      err_q     <= err_d;
      rdata_q   <= rdata_d;
    end
  end

  // Stall drops in DONE so the core advances exactly once per access.
  assign stall_o     = (in_idle && access) || (state_q == REQ);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign rdata_o     = rdata_q;
  assign mem_req_o   = req_q;
  assign mem_we_o    = cmd_q.we;
  assign mem_addr_o  = cmd_q.addr;
  assign mem_be_o    = cmd_q.be;
  assign mem_wdata_o = cmd_q.wdata;

endmodule
